// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, address map and small datapath helpers for the cpu
package mips_pkg;
   localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
   localparam logic [31:0] DATA_BASE = 32'h0000_0000;
   localparam int IM_WORDS = 1024;
   localparam int DM_WORDS = 1024;
   localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
   typedef enum logic [1:0] {NPC_PC4, NPC_BR, NPC_J} npc_op_t;
   typedef enum logic {REG_ALU, REG_MEM} reg_src_t;
   typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB} fwd_t;
   typedef struct packed {
      alu_op_t    alu;
      logic       imm_src;
      reg_src_t   src;
      logic       wr;
      logic       st;
      logic [4:0] dst;
   } ctl_t;
   function automatic logic [31:0] alu(input alu_op_t f, input logic [31:0] a, input logic [31:0] b);
      return f == ALU_SUB ? a - b : f == ALU_AND ? a & b : f == ALU_OR ? a | b :
             f == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
   endfunction
   function automatic fwd_t fwd_sel(input logic [4:0] r, input ctl_t m, input ctl_t w);
      return m.wr && m.dst == r ? FWD_MEM : w.wr && w.dst == r ? FWD_WB : FWD_RF;
   endfunction
   function automatic logic [31:0] fwd_mux(input fwd_t s, input logic [31:0] m, input logic [31:0] w, input logic [31:0] r);
      return s == FWD_MEM ? m : s == FWD_WB ? w : r;
   endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 31 general registers, $0 hardwired to zero, write-through read ports
module reg_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] rf [1:31];
   // clear all registers on reset; writes to $0 are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < 32; i++) rf[i] <= '0;
      end else if (we && wa != 5'd0) begin
         rf[wa] <= wd;
      end
   end
   assign rd1 = ra1 == 5'd0 ? '0 : we && wa == ra1 ? wd : rf[ra1];
   assign rd2 = ra2 == 5'd0 ? '0 : we && wa == ra2 ? wd : rf[ra2];
endmodule

// File: rtl/cpu.sv
// cpu: five-stage pipelined MIPS-subset core with internal instruction and data memories
module cpu
   import mips_pkg::*;
(
   input logic clk,
   input logic rst
);
   localparam int IW = $clog2(IM_WORDS);
   localparam int DW = $clog2(DM_WORDS);
   logic [31:0] IF_PC, ID_PC, EX_PC, MEM_PC, WB_PC;
   logic [31:0] if_ins, id_ins, im_off, dm_off;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, id_dst, ex_rs, ex_rt;
   logic [31:0] imm, pc4, rd1, rd2, cmp_a, cmp_b, npc;
   logic        rtype, rd_rs, rd_rt, is_beq, is_j, hit_ex, hit_mem, stall, take;
   npc_op_t     npc_op;
   ctl_t        id_ctl, ex_ctl, mem_ctl, wb_ctl;
   logic [31:0] ex_a, ex_b, ex_imm, ex_x, ex_y, ex_res;
   logic [31:0] mem_alu, mem_sd, mem_rd, wb_alu, wb_md, wb_val;
   logic        unused_ok;
   assign im_off = IF_PC - TEXT_BASE;
   assign dm_off = mem_alu - DATA_BASE;
   if (1) begin : insMem
      if (1) begin : innerIM
         logic [31:0] ROM [IM_WORDS];
         assign if_ins = ROM[im_off[IW+1:2]];
      end
   end
   assign op = id_ins[31:26];
   assign rs = id_ins[25:21];
   assign rt = id_ins[20:16];
   assign rd = id_ins[15:11];
   assign fn = id_ins[5:0];
   assign imm = {{16{id_ins[15]}}, id_ins[15:0]};
   assign rtype = op == OP_R && (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT);
   assign is_beq = op == OP_BEQ;
   assign is_j = op == OP_J;
   assign rd_rs = rtype || op == OP_ADDI || op == OP_LW || op == OP_SW || is_beq;
   assign rd_rt = rtype || op == OP_SW || is_beq;
   assign id_dst = rtype ? rd : rt;
   // decode the ID instruction; unsupported encodings leave every write disabled
   always_comb begin
      id_ctl = '0;
      id_ctl.alu = !rtype ? ALU_ADD : fn == F_SUB ? ALU_SUB : fn == F_AND ? ALU_AND :
                   fn == F_OR ? ALU_OR : fn == F_SLT ? ALU_SLT : ALU_ADD;
      id_ctl.imm_src = !rtype;
      id_ctl.src = op == OP_LW ? REG_MEM : REG_ALU;
      id_ctl.wr = (rtype || op == OP_ADDI || op == OP_LW) && id_dst != 5'd0;
      id_ctl.st = op == OP_SW;
      id_ctl.dst = id_dst;
   end
   reg_file regFile (
      .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2),
      .we(wb_ctl.wr), .wa(wb_ctl.dst), .wd(wb_val)
   );
   assign hit_ex = ex_ctl.wr && ((rd_rs && ex_ctl.dst == rs) || (rd_rt && ex_ctl.dst == rt));
   assign hit_mem = mem_ctl.wr && mem_ctl.src == REG_MEM && ((rd_rs && mem_ctl.dst == rs) || (rd_rt && mem_ctl.dst == rt));
   assign stall = (hit_ex && (ex_ctl.src == REG_MEM || is_beq)) || (is_beq && hit_mem);
   assign cmp_a = fwd_mux(fwd_sel(rs, mem_ctl, wb_ctl), mem_alu, wb_val, rd1);
   assign cmp_b = fwd_mux(fwd_sel(rt, mem_ctl, wb_ctl), mem_alu, wb_val, rd2);
   assign pc4 = ID_PC + 32'd4;
   assign npc_op = stall ? NPC_PC4 : is_j ? NPC_J : is_beq && cmp_a == cmp_b ? NPC_BR : NPC_PC4;
   assign take = npc_op != NPC_PC4;
   assign npc = stall ? IF_PC : npc_op == NPC_J ? {pc4[31:28], id_ins[25:0], 2'b00} :
                npc_op == NPC_BR ? pc4 + {imm[29:0], 2'b00} : IF_PC + 32'd4;
   // PC and IF/ID: hold on stall, squash the fetched word on a taken branch or jump
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         IF_PC <= TEXT_BASE;
         ID_PC <= '0;
         id_ins <= '0;
      end else begin
         IF_PC <= npc;
         if (!stall) begin
            ID_PC <= take ? '0 : IF_PC;
            id_ins <= take ? '0 : if_ins;
         end
      end
   end
   // ID/EX: a stall turns the EX slot into a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         EX_PC <= '0;
         ex_ctl <= '0;
         ex_rs <= '0;
         ex_rt <= '0;
         ex_a <= '0;
         ex_b <= '0;
         ex_imm <= '0;
      end else begin
         EX_PC <= stall ? '0 : ID_PC;
         ex_ctl <= stall ? '0 : id_ctl;
         ex_rs <= rs;
         ex_rt <= rt;
         ex_a <= rd1;
         ex_b <= rd2;
         ex_imm <= imm;
      end
   end
   assign ex_x = fwd_mux(fwd_sel(ex_rs, mem_ctl, wb_ctl), mem_alu, wb_val, ex_a);
   assign ex_y = fwd_mux(fwd_sel(ex_rt, mem_ctl, wb_ctl), mem_alu, wb_val, ex_b);
   assign ex_res = alu(ex_ctl.alu, ex_x, ex_ctl.imm_src ? ex_imm : ex_y);
   // EX/MEM and MEM/WB pipeline registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         MEM_PC <= '0;
         mem_ctl <= '0;
         mem_alu <= '0;
         mem_sd <= '0;
         WB_PC <= '0;
         wb_ctl <= '0;
         wb_alu <= '0;
         wb_md <= '0;
      end else begin
         MEM_PC <= EX_PC;
         mem_ctl <= ex_ctl;
         mem_alu <= ex_res;
         mem_sd <= ex_y;
         WB_PC <= MEM_PC;
         wb_ctl <= mem_ctl;
         wb_alu <= mem_alu;
         wb_md <= mem_rd;
      end
   end
   if (1) begin : dataMem
      if (1) begin : innerDM
         logic [31:0] dmem [DM_WORDS];
         // stores commit on the rising edge in MEM; contents survive reset
         always_ff @(posedge clk) begin
            if (mem_ctl.st) dmem[dm_off[DW+1:2]] <= mem_sd;
         end
         assign mem_rd = dmem[dm_off[DW+1:2]];
      end
   end
   assign wb_val = wb_ctl.src == REG_MEM ? wb_md : wb_alu;
   assign unused_ok = ^{id_ins[10:6], im_off[31:IW+2], im_off[1:0], dm_off[31:DW+2], dm_off[1:0],
                        WB_PC, mem_ctl.alu, mem_ctl.imm_src, wb_ctl.alu, wb_ctl.imm_src, wb_ctl.st};
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs with hand-computed register, memory and pipeline-PC checks
module tb_cpu;
   localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
   localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND_ = 6'h24, OR_ = 6'h25, SLT = 6'h2A;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_vec = 0;
   int n_bad = 0;
   cpu dut (.clk(clk), .rst(rst));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] rr(input logic [5:0] f, input int s, input int t, input int d);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, f};
   endfunction
   function automatic logic [31:0] ri(input logic [5:0] o, input int s, input int t, input int imm);
      return {o, 5'(s), 5'(t), 16'(imm)};
   endfunction
   function automatic logic [31:0] rj(input int tgt);
      return {6'h02, 26'(tgt >> 2)};
   endfunction
   task automatic hold;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 1024; i++) dut.insMem.innerIM.ROM[i] = '0;
   endtask
   task automatic put(input int a, input logic [31:0] w);
      dut.insMem.innerIM.ROM[a] = w;
   endtask
   task automatic go;
      @(negedge clk);
      rst = 1'b1;
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_if_pc", dut.IF_PC, 32'h3000);
      chk("rst_id_pc", dut.ID_PC, 32'h0);
      chk("rst_ex_pc", dut.EX_PC, 32'h0);
      chk("rst_rf1", dut.regFile.rf[1], 32'h0);
      // forwarding from MEM and WB, plus first-fetch and write-back latency
      hold;
      put(0, ri(ADDI, 0, 1, 5));
      put(1, ri(ADDI, 1, 2, 3));
      put(2, rr(ADD, 1, 2, 3));
      go;
      step(1);
      chk("t1_id_pc_e1", dut.ID_PC, 32'h3000);
      chk("t1_if_pc_e1", dut.IF_PC, 32'h3004);
      step(3);
      chk("t1_wb_pc_e4", dut.WB_PC, 32'h3000);
      chk("t1_rf1_e4", dut.regFile.rf[1], 32'h0);
      step(1);
      chk("t1_rf1_e5", dut.regFile.rf[1], 32'd5);
      step(5);
      chk("t1_rf2", dut.regFile.rf[2], 32'd8);
      chk("t1_rf3", dut.regFile.rf[3], 32'd13);
      // signed compare and logic ops
      hold;
      put(0, ri(ADDI, 0, 4, -1));
      put(1, rr(SLT, 4, 0, 5));
      put(2, rr(SUB, 0, 4, 6));
      put(3, rr(AND_, 4, 6, 7));
      put(4, rr(OR_, 4, 0, 8));
      go;
      step(12);
      chk("t2_rf5", dut.regFile.rf[5], 32'd1);
      chk("t2_rf6", dut.regFile.rf[6], 32'd1);
      chk("t2_rf7", dut.regFile.rf[7], 32'd1);
      chk("t2_rf8", dut.regFile.rf[8], 32'hFFFF_FFFF);
      // store, load and load-use stall
      hold;
      put(0, ri(ADDI, 0, 2, 7));
      put(1, ri(SW, 0, 2, 84));
      put(2, ri(LW, 0, 3, 84));
      put(3, rr(ADD, 3, 3, 4));
      go;
      step(5);
      chk("t3_ex_pc_bubble", dut.EX_PC, 32'h0);
      chk("t3_id_pc_hold", dut.ID_PC, 32'h300C);
      step(1);
      chk("t3_ex_pc_add", dut.EX_PC, 32'h300C);
      step(6);
      chk("t3_dmem21", dut.dataMem.innerDM.dmem[21], 32'd7);
      chk("t3_rf4", dut.regFile.rf[4], 32'd14);
      // counted loop: beq and j squash the following fetch
      hold;
      put(0, ri(ADDI, 0, 1, 3));
      put(1, ri(ADDI, 1, 1, -1));
      put(2, ri(ADDI, 10, 10, 1));
      put(3, ri(BEQ, 1, 0, 2));
      put(4, rj(32'h3004));
      put(5, ri(ADDI, 9, 9, 1));
      put(6, ri(SW, 0, 1, 80));
      go;
      step(50);
      chk("t4_rf1", dut.regFile.rf[1], 32'd0);
      chk("t4_iters", dut.regFile.rf[10], 32'd3);
      chk("t4_squashed", dut.regFile.rf[9], 32'd0);
      chk("t4_dmem20", dut.dataMem.innerDM.dmem[20], 32'd0);
      // beq on a just-loaded value: two stall cycles, then taken
      hold;
      put(0, ri(ADDI, 0, 2, 9));
      put(1, ri(SW, 0, 2, 84));
      put(2, ri(LW, 0, 5, 84));
      put(3, ri(BEQ, 5, 2, 2));
      put(4, ri(ADDI, 0, 6, 1));
      put(5, ri(ADDI, 0, 7, 1));
      put(6, ri(ADDI, 0, 8, 32'h55));
      go;
      step(4);
      chk("t5_dmem21_e4", dut.dataMem.innerDM.dmem[21], 32'd7);
      step(1);
      chk("t5_dmem21_e5", dut.dataMem.innerDM.dmem[21], 32'd9);
      chk("t5_ex_pc_e5", dut.EX_PC, 32'h0);
      chk("t5_id_pc_e5", dut.ID_PC, 32'h300C);
      step(1);
      chk("t5_ex_pc_e6", dut.EX_PC, 32'h0);
      chk("t5_id_pc_e6", dut.ID_PC, 32'h300C);
      step(1);
      chk("t5_ex_pc_e7", dut.EX_PC, 32'h300C);
      chk("t5_id_pc_e7", dut.ID_PC, 32'h0);
      chk("t5_if_pc_e7", dut.IF_PC, 32'h3018);
      step(1);
      chk("t5_id_pc_e8", dut.ID_PC, 32'h3018);
      step(8);
      chk("t5_rf5", dut.regFile.rf[5], 32'd9);
      chk("t5_rf6", dut.regFile.rf[6], 32'd0);
      chk("t5_rf7", dut.regFile.rf[7], 32'd0);
      chk("t5_rf8", dut.regFile.rf[8], 32'h55);
      // asynchronous reset in the middle of a program
      hold;
      put(0, ri(ADDI, 0, 1, 5));
      put(1, ri(ADDI, 1, 2, 3));
      put(2, rr(ADD, 1, 2, 3));
      go;
      step(6);
      chk("t6_rf1_before", dut.regFile.rf[1], 32'd5);
      #2 rst = 1'b0;
      #1;
      chk("t6_if_pc", dut.IF_PC, 32'h3000);
      chk("t6_id_pc", dut.ID_PC, 32'h0);
      chk("t6_rf1", dut.regFile.rf[1], 32'h0);
      chk("t6_dmem21", dut.dataMem.innerDM.dmem[21], 32'd9);
      go;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
